// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a CPU and a DMA requester share one memory port.
// CPU wins ties unless the DMA has waited through STARVE_LIM CPU grants.
// Every access takes a fixed 2+MEM_LAT edges from request sample to ack.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no access; samples requests, grants a winner on the edge
// S_ACCESS| single cycle with m_en high, latched access on m_*
// S_WAIT  | memory latency, MEM_LAT cycles, down-counter
// S_RESP  | read data captured; owner's ack is issued next cycle
module mem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic [1:0]        owner
);

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DMA  = 2'b10;
  localparam logic [3:0] LP_STARVE   = 4'(STARVE_LIM);
  localparam logic [2:0] LP_WAIT_LD  = 3'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_grant_c;
  logic   w_grant_d;

  logic [2:0]        r_wait_cnt;
  logic [3:0]        r_starve;
  logic              r_we_lat;
  logic              r_m_en;
  logic              r_m_we;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  logic [DATA_W-1:0] r_c_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_c_ack;
  logic              r_d_ack;
  logic              r_busy;
  logic [1:0]        r_owner;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and grant decode; DMA is forced only when both request and
  // the CPU has already taken STARVE_LIM grants past a waiting DMA.
  always_comb begin
    w_next    = r_state;
    w_grant_c = 1'b0;
    w_grant_d = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (c_req && !(d_req && (r_starve == LP_STARVE))) begin
          w_grant_c = 1'b1;
          w_next    = S_ACCESS;
        end else if (d_req) begin
          w_grant_d = 1'b1;
          w_next    = S_ACCESS;
        end
      end
      S_ACCESS: w_next = S_WAIT;
      S_WAIT:   if (r_wait_cnt == 3'd0) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Registered outputs, access latch, latency counter and starvation count.
  // The ack is launched on the edge leaving RESP, which places it exactly
  // 2+MEM_LAT edges after the grant edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= 3'd0;
      r_starve   <= 4'd0;
      r_we_lat   <= 1'b0;
      r_m_en     <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_c_rdata  <= '0;
      r_d_rdata  <= '0;
      r_c_ack    <= 1'b0;
      r_d_ack    <= 1'b0;
      r_busy     <= 1'b0;
      r_owner    <= OWN_NONE;
    end else begin
      r_m_en  <= 1'b0;
      r_m_we  <= 1'b0;
      r_c_ack <= (r_state == S_RESP) && (r_owner == OWN_CPU);
      r_d_ack <= (r_state == S_RESP) && (r_owner == OWN_DMA);
      r_busy  <= (w_next != S_IDLE);

      if (w_grant_c) begin
        r_m_en    <= 1'b1;
        r_m_we    <= c_we;
        r_we_lat  <= c_we;
        r_m_addr  <= c_addr;
        r_m_wdata <= c_wdata;
        r_owner   <= OWN_CPU;
        if (d_req && (r_starve != LP_STARVE)) r_starve <= r_starve + 4'd1;
      end else if (w_grant_d) begin
        r_m_en    <= 1'b1;
        r_m_we    <= d_we;
        r_we_lat  <= d_we;
        r_m_addr  <= d_addr;
        r_m_wdata <= d_wdata;
        r_owner   <= OWN_DMA;
        r_starve  <= 4'd0;
      end else if (w_next == S_IDLE) begin
        r_owner <= OWN_NONE;
      end

      if (r_state == S_ACCESS) r_wait_cnt <= LP_WAIT_LD;

      if (r_state == S_WAIT) begin
        if (r_wait_cnt != 3'd0) begin
          r_wait_cnt <= r_wait_cnt - 3'd1;
        end else if (!r_we_lat) begin
          if (r_owner == OWN_CPU) r_c_rdata <= m_rdata;
          if (r_owner == OWN_DMA) r_d_rdata <= m_rdata;
        end
      end
    end
  end

  assign m_en    = r_m_en;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign c_rdata = r_c_rdata;
  assign d_rdata = r_d_rdata;
  assign c_ack   = r_c_ack;
  assign d_ack   = r_d_ack;
  assign busy    = r_busy;
  assign owner   = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 uses MEM_LAT=1, instance 1 MEM_LAT=3.
// Expected transactions go into a scoreboard queue when driven and are
// popped when the matching ack appears.
module tb_mem_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  typedef struct {
    bit          dma;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] crd;
    logic [31:0] drd;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n   [2];
  logic        c_req   [2];
  logic        c_we    [2];
  logic [31:0] c_addr  [2];
  logic [31:0] c_wdata [2];
  logic [31:0] c_rdata [2];
  logic        c_ack   [2];
  logic        d_req   [2];
  logic        d_we    [2];
  logic [31:0] d_addr  [2];
  logic [31:0] d_wdata [2];
  logic [31:0] d_rdata [2];
  logic        d_ack   [2];
  logic        m_en    [2];
  logic        m_we    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];
  logic        busy    [2];
  logic [1:0]  owner   [2];

  logic [31:0] exp_crd [2];
  logic [31:0] exp_drd [2];
  exp_t        sb[$];
  int          order_q[$];
  int          n_checks;
  int          n_fail;

  mem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(LAT_A), .STARVE_LIM(4)) u_dut_a (
    .clk(clk), .reset(rst_n[0]),
    .c_req(c_req[0]), .c_we(c_we[0]), .c_addr(c_addr[0]), .c_wdata(c_wdata[0]),
    .c_rdata(c_rdata[0]), .c_ack(c_ack[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_rdata(d_rdata[0]), .d_ack(d_ack[0]),
    .m_en(m_en[0]), .m_we(m_we[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
    .m_rdata(m_rdata[0]), .busy(busy[0]), .owner(owner[0])
  );

  mem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(LAT_B), .STARVE_LIM(4)) u_dut_b (
    .clk(clk), .reset(rst_n[1]),
    .c_req(c_req[1]), .c_we(c_we[1]), .c_addr(c_addr[1]), .c_wdata(c_wdata[1]),
    .c_rdata(c_rdata[1]), .c_ack(c_ack[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_rdata(d_rdata[1]), .d_ack(d_ack[1]),
    .m_en(m_en[1]), .m_we(m_we[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
    .m_rdata(m_rdata[1]), .busy(busy[1]), .owner(owner[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one access on instance k, follow it to its ack and score it.
  // The request is dropped right after the grant edge (during ACCESS);
  // with scramble set, the requester's fields change during WAIT.
  task automatic do_txn(input int k, input bit dma, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] mem, input bit scramble);
    exp_t        e;
    int          cyc;
    bit          got;
    bit          oth;
    int          en_cnt;
    logic        sw;
    logic [31:0] sa;
    logic [31:0] sd;
    cyc = 0; got = 0; oth = 0; en_cnt = 0; sw = 0; sa = '0; sd = '0;
    m_rdata[k] = mem;
    if (!we) begin
      if (dma) exp_drd[k] = mem;
      else     exp_crd[k] = mem;
    end
    e.dma = dma; e.we = we; e.addr = addr; e.wdata = wdata;
    e.crd = exp_crd[k]; e.drd = exp_drd[k];
    e.lat = 2 + ((k == 0) ? LAT_A : LAT_B);
    sb.push_back(e);
    if (dma) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
    end else begin
      c_req[k] = 1'b1; c_we[k] = we; c_addr[k] = addr; c_wdata[k] = wdata;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      cyc++;
      if (i == 0) begin
        c_req[k] = 1'b0;
        d_req[k] = 1'b0;
      end
      if (i == 1 && scramble) begin
        c_addr[k] = 32'h99; c_wdata[k] = ~wdata; c_we[k] = ~we;
        d_addr[k] = 32'h99; d_wdata[k] = ~wdata; d_we[k] = ~we;
      end
      if (m_en[k]) begin
        en_cnt++;
        sw = m_we[k]; sa = m_addr[k]; sd = m_wdata[k];
      end
      if (dma ? c_ack[k] : d_ack[k]) oth = 1'b1;
      if (dma ? d_ack[k] : c_ack[k]) got = 1'b1;
    end
    e = sb.pop_front();
    check("ack_seen", 64'(got), 64'd1);
    check("ack_latency", 64'(cyc - 1), 64'(e.lat));
    check("m_en_cycles", 64'(en_cnt), 64'd1);
    check("m_we", 64'(sw), 64'(e.we));
    check("m_addr", 64'(sa), 64'(e.addr));
    if (e.we) check("m_wdata", 64'(sd), 64'(e.wdata));
    check("c_rdata", 64'(c_rdata[k]), 64'(e.crd));
    check("d_rdata", 64'(d_rdata[k]), 64'(e.drd));
    check("other_ack", 64'(oth), 64'd0);
    check("m_addr_hold", 64'(m_addr[k]), 64'(e.addr));
    tick();
    check("ack_single", 64'(dma ? d_ack[k] : c_ack[k]), 64'd0);
    check("owner_idle", 64'(owner[k]), 64'd0);
    check("busy_idle", 64'(busy[k]), 64'd0);
  endtask

  initial begin
    bit simul;
    bit stray_ack;
    int ngr;
    n_checks = 0;
    n_fail   = 0;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0;
      c_req[k] = 1'b0; c_we[k] = 1'b0; c_addr[k] = '0; c_wdata[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
      m_rdata[k] = '0;
      exp_crd[k] = '0;
      exp_drd[k] = '0;
    end

    // Reset state on both instances.
    repeat (2) tick();
    for (int k = 0; k < 2; k++) begin
      check("rst_m_en", 64'(m_en[k]), 64'd0);
      check("rst_busy", 64'(busy[k]), 64'd0);
      check("rst_owner", 64'(owner[k]), 64'd0);
      check("rst_acks", 64'({c_ack[k], d_ack[k]}), 64'd0);
      check("rst_m_addr", 64'(m_addr[k]), 64'd0);
      check("rst_rdata", 64'({c_rdata[k], d_rdata[k]}), 64'd0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (2) tick();
    check("idle_no_req", 64'(busy[0]), 64'd0);

    // CPU read of 0x10, memory returns 0xDEADBEEF, MEM_LAT=1.
    do_txn(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // DMA read then DMA write of 0x55 to 0x20 with MEM_LAT=3.
    do_txn(1, 1'b1, 1'b0, 32'h24, 32'h0, 32'hCAFE0001, 1'b0);
    do_txn(1, 1'b1, 1'b1, 32'h20, 32'h55, 32'h12345678, 1'b0);

    // CPU address changed to 0x99 during WAIT; latched 0x10 must stay.
    do_txn(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0000ABCD, 1'b1);

    // CPU write; c_rdata holds.
    do_txn(0, 1'b0, 1'b1, 32'h44, 32'hA5A5A5A5, 32'h11111111, 1'b0);

    // Both requesting continuously: CPU x4, DMA, CPU.
    order_q.push_back(1); order_q.push_back(1); order_q.push_back(1);
    order_q.push_back(1); order_q.push_back(2); order_q.push_back(1);
    m_rdata[0] = 32'h5A5A0000;
    c_we[0] = 1'b0; c_addr[0] = 32'h100;
    d_we[0] = 1'b0; d_addr[0] = 32'h200;
    c_req[0] = 1'b1; d_req[0] = 1'b1;
    simul = 1'b0;
    ngr = 0;
    for (int i = 0; i < 100 && ngr < 6; i++) begin
      tick();
      if (c_ack[0] && d_ack[0]) simul = 1'b1;
      if (m_en[0]) begin
        check("grant_order", 64'(owner[0]), 64'(order_q.pop_front()));
        ngr++;
      end
    end
    c_req[0] = 1'b0; d_req[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (c_ack[0] && d_ack[0]) simul = 1'b1;
    end
    check("grant_count", 64'(ngr), 64'd6);
    check("acks_exclusive", 64'(simul), 64'd0);
    exp_crd[0] = 32'h5A5A0000;
    exp_drd[0] = 32'h5A5A0000;
    check("starve_c_rdata", 64'(c_rdata[0]), 64'(exp_crd[0]));
    check("starve_d_rdata", 64'(d_rdata[0]), 64'(exp_drd[0]));

    // Reset pulled low during WAIT aborts the access with no ack.
    m_rdata[0] = 32'h77777777;
    c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 32'h50;
    tick();
    c_req[0] = 1'b0;
    tick();
    check("pre_reset_busy", 64'(busy[0]), 64'd1);
    #2;
    rst_n[0] = 1'b0;
    #1;
    check("reset_busy", 64'(busy[0]), 64'd0);
    check("reset_m_en", 64'(m_en[0]), 64'd0);
    check("reset_owner", 64'(owner[0]), 64'd0);
    stray_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (c_ack[0] || d_ack[0]) stray_ack = 1'b1;
    end
    rst_n[0] = 1'b1;
    exp_crd[0] = '0;
    exp_drd[0] = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (c_ack[0] || d_ack[0]) stray_ack = 1'b1;
    end
    check("reset_no_ack", 64'(stray_ack), 64'd0);
    check("reset_c_rdata", 64'(c_rdata[0]), 64'd0);

    // Fresh CPU request after reset release is serviced normally.
    do_txn(0, 1'b0, 1'b0, 32'h30, 32'h0, 32'h0BADF00D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
